mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter BUS_WIDTH, default 32, data/address width.
REQ-003 Parameter MEM_BYTES, default 256, byte-addressable memory depth.
REQ-004 Port clk  input  1  system clock, all state on rising edge.
REQ-005 Port rst  input  1  asynchronous active-low reset.
REQ-006 Ports a_req / b_req  input  1  access request, port A (load/store), port B (loader/debug).
REQ-007 Ports a_addr / b_addr  input  32  byte address.
REQ-008 Ports a_wdata / b_wdata  input  32  write data, right-aligned.
REQ-009 Ports a_we / b_we  input  1  1 = write, 0 = read.
REQ-010 Ports a_size / b_size  input  2  access size: 00 byte, 01 half word, 10 word, 11 illegal.
REQ-011 Ports a_sz_ex / b_sz_ex  input  1  read result: 1 = sign-extend, 0 = zero-extend.
REQ-012 Ports a_gnt / b_gnt  output  1  request accepted this cycle.
REQ-013 Ports a_done / b_done  output  1  one-cycle completion pulse.
REQ-014 Ports a_err / b_err  output  1  valid with done: access rejected.
REQ-015 Ports a_rdata / b_rdata  output  32  read data, valid with done on a read.
REQ-016 Ports mem_address, mem_data_in  output  32  memory address and write data.
REQ-017 Ports mem_wr_en  output  1, mem_size  output  2, mem_sz_ex  output  1  memory controls.
REQ-018 Port mem_data_out  input  32  memory read data, combinational from mem_address; writes commit on the clk edge while mem_wr_en = 1.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP.
REQ-020 IDLE: when any req = 1, assert gnt to exactly one port combinationally, latch its addr/wdata/we/size/sz_ex into the command register, and advance.
REQ-021 Arbitration: single request wins; if both request, the port not served last wins (round-robin); last-served pointer updates on each grant.
REQ-022 Requester holds req and fields stable until gnt; it may drop or change them the cycle after gnt.
REQ-023 Error check in IDLE on the granted command: size = 11, word with addr[1:0] != 0, half word with addr[0] != 0, or addr + bytes > MEM_BYTES.
REQ-024 Legal command: IDLE -> ACCESS; erroneous command: IDLE -> RESP, memory untouched.
REQ-025 ACCESS (exactly one cycle): mem_* driven from the command register; mem_wr_en = we; mem_data_out captured into the response register at the edge ending ACCESS.
REQ-026 RESP (exactly one cycle): assert done (plus err if flagged) and rdata on the served port only; the other port's done/err = 0; then return to IDLE.
REQ-027 Latency: gnt cycle T; done at T+2 (legal) or T+1 (error); one access completes at most every 3 cycles.
REQ-028 rdata holds its last value until the next read completes on that port; a write or error leaves rdata unchanged.
REQ-029 Outside ACCESS: mem_wr_en = 0, mem_address = 0, mem_data_in = 0, mem_size = 10, mem_sz_ex = 0.
REQ-030 gnt is never asserted outside IDLE; requests arriving in ACCESS/RESP wait.

Reset
REQ-031 rst = 0 SHALL immediately force state IDLE, mem_wr_en = 0, and all gnt/done/err = 0 without waiting for a clock edge.
REQ-032 Reset values: rdata = 0, command register = 0, last-served pointer = B (A wins the first tie).
REQ-033 Reset during ACCESS SHALL abort the access with no write and no done pulse.

Structure
REQ-034 Shared package mem_pkg SHALL hold BUS_WIDTH, MEM_VECTOR_SIZE (256), and the size codes WORD = 10, HALF_WORD = 01, BYTE = 00; the FSM state encoding stays local.
REQ-035 One sub-module, mem_access_check, SHALL implement the combinational legality check of REQ-023.

Verification
REQ-036 After reset, A writes word 0x000000FF to addr 0, then reads addr 0 byte with sz_ex = 1 -> write done at T+2 with err = 0; read rdata = 0xFFFFFFFF.
REQ-037 a_req and b_req both high in the same IDLE cycle after reset -> a_gnt first, b_gnt 3 cycles later; repeated simultaneous requests alternate A, B, A.
REQ-038 B writes half word 0xFFFF at addr 8, then reads it with sz_ex = 0 -> rdata = 0x0000FFFF; sz_ex = 1 -> 0xFFFFFFFF.
REQ-039 Word write to addr 6, half word to addr 3, size 11, and word to addr 254 -> each gives done + err at T+1; mem_wr_en never 1; a subsequent read of the target addresses returns the previous contents.
REQ-040 Assert rst = 0 mid-ACCESS of a word write of 0xFFFFFFFF to addr 12 -> mem_wr_en drops immediately, no done; reading addr 12 after reset returns the pre-write value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory arbiter: bus width, memory depth and access size codes.
package mem_pkg;

    localparam int BUS_WIDTH       = 32;
    localparam int MEM_VECTOR_SIZE = 256;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Byte count of a size code; the illegal code is flagged separately by the checker.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            BYTE:      size_bytes = 3'd1;
            HALF_WORD: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check of one command: size code, natural alignment and
// bounds against the memory depth.
module mem_access_check #(
    parameter int BUS_WIDTH = mem_pkg::BUS_WIDTH,
    parameter int MEM_BYTES = mem_pkg::MEM_VECTOR_SIZE
) (
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic [1:0]           size,
    output logic                 err
);
    import mem_pkg::*;

    // One extra bit so that addr + bytes cannot wrap past the top of the address space.
    localparam logic [BUS_WIDTH:0] LIMIT = (BUS_WIDTH+1)'(MEM_BYTES);

    logic [BUS_WIDTH:0] end_addr;
    logic               misaligned;

    always_comb begin
        misaligned = 1'b0;
        end_addr   = {1'b0, addr} + (BUS_WIDTH+1)'(size_bytes(size));
        case (size)
            WORD:      misaligned = (addr[1:0] != 2'b00);
            HALF_WORD: misaligned = addr[0];
            default:   misaligned = 1'b0;
        endcase
        err = (size == 2'b11) || misaligned || (end_addr > LIMIT);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single combinational-read memory.
// Each access runs IDLE -> ACCESS -> RESP, or IDLE -> RESP when the command is rejected.
module mem_arbiter #(
    parameter int BUS_WIDTH = mem_pkg::BUS_WIDTH,
    parameter int MEM_BYTES = mem_pkg::MEM_VECTOR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic [BUS_WIDTH-1:0] a_addr,
    input  logic [BUS_WIDTH-1:0] a_wdata,
    input  logic                 a_we,
    input  logic [1:0]           a_size,
    input  logic                 a_sz_ex,
    output logic                 a_gnt,
    output logic                 a_done,
    output logic                 a_err,
    output logic [BUS_WIDTH-1:0] a_rdata,
    input  logic                 b_req,
    input  logic [BUS_WIDTH-1:0] b_addr,
    input  logic [BUS_WIDTH-1:0] b_wdata,
    input  logic                 b_we,
    input  logic [1:0]           b_size,
    input  logic                 b_sz_ex,
    output logic                 b_gnt,
    output logic                 b_done,
    output logic                 b_err,
    output logic [BUS_WIDTH-1:0] b_rdata,
    output logic [BUS_WIDTH-1:0] mem_address,
    output logic [BUS_WIDTH-1:0] mem_data_in,
    output logic                 mem_wr_en,
    output logic [1:0]           mem_size,
    output logic                 mem_sz_ex,
    input  logic [BUS_WIDTH-1:0] mem_data_out
);
    import mem_pkg::*;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t state_reg, state_next;

    logic                 last_reg;
    logic                 port_reg;
    logic                 err_reg;
    logic [BUS_WIDTH-1:0] cmd_addr_reg;
    logic [BUS_WIDTH-1:0] cmd_wdata_reg;
    logic                 cmd_we_reg;
    logic [1:0]           cmd_size_reg;
    logic                 cmd_sz_ex_reg;
    logic [BUS_WIDTH-1:0] rdata_reg [2];
    logic [1:0]           done_vec;

    logic                 grant;
    logic                 sel;
    logic                 chk_err;
    logic [BUS_WIDTH-1:0] sel_addr;
    logic [BUS_WIDTH-1:0] sel_wdata;
    logic                 sel_we;
    logic [1:0]           sel_size;
    logic                 sel_sz_ex;

    // B wins when alone, or on a tie when A was served last.
    assign sel       = b_req && (!a_req || (last_reg == PORT_A));
    assign sel_addr  = sel ? b_addr  : a_addr;
    assign sel_wdata = sel ? b_wdata : a_wdata;
    assign sel_we    = sel ? b_we    : a_we;
    assign sel_size  = sel ? b_size  : a_size;
    assign sel_sz_ex = sel ? b_sz_ex : a_sz_ex;

    mem_access_check #(
        .BUS_WIDTH (BUS_WIDTH),
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .addr (sel_addr),
        .size (sel_size),
        .err  (chk_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            last_reg      <= PORT_B;
            port_reg      <= PORT_A;
            err_reg       <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            cmd_we_reg    <= 1'b0;
            cmd_size_reg  <= 2'b00;
            cmd_sz_ex_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                last_reg      <= sel;
                port_reg      <= sel;
                err_reg       <= chk_err;
                cmd_addr_reg  <= sel_addr;
                cmd_wdata_reg <= sel_wdata;
                cmd_we_reg    <= sel_we;
                cmd_size_reg  <= sel_size;
                cmd_sz_ex_reg <= sel_sz_ex;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant       = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        mem_wr_en   = 1'b0;
        mem_size    = WORD;
        mem_sz_ex   = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by reset so a pending request cannot be granted while reset is held.
                if (rst && (a_req || b_req)) begin
                    grant      = 1'b1;
                    state_next = chk_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_address = cmd_addr_reg;
                mem_data_in = cmd_wdata_reg;
                mem_wr_en   = cmd_we_reg;
                mem_size    = cmd_size_reg;
                mem_sz_ex   = cmd_sz_ex_reg;
                state_next  = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-port response registers; only a read completing on that port updates them.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdata_reg[gi] <= '0;
            end else if (state_reg == ACCESS && !cmd_we_reg && port_reg == 1'(gi)) begin
                rdata_reg[gi] <= mem_data_out;
            end
        end
        assign done_vec[gi] = (state_reg == RESP) && (port_reg == 1'(gi));
    end

    assign a_gnt   = grant && !sel;
    assign b_gnt   = grant && sel;
    assign a_done  = done_vec[0];
    assign b_done  = done_vec[1];
    assign a_err   = done_vec[0] && err_reg;
    assign b_err   = done_vec[1] && err_reg;
    assign a_rdata = rdata_reg[0];
    assign b_rdata = rdata_reg[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory model behind the mem_* port.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        a_req, b_req, a_we, b_we, a_sz_ex, b_sz_ex;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic [1:0]  a_size, b_size;
    logic        a_gnt, b_gnt, a_done, b_done, a_err, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_wr_en, mem_sz_ex;
    logic [1:0]  mem_size;

    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;
    int          wr_seen = 0;

    mem_arbiter dut (
        .clk (clk), .rst (rst),
        .a_req (a_req), .a_addr (a_addr), .a_wdata (a_wdata), .a_we (a_we),
        .a_size (a_size), .a_sz_ex (a_sz_ex), .a_gnt (a_gnt), .a_done (a_done),
        .a_err (a_err), .a_rdata (a_rdata),
        .b_req (b_req), .b_addr (b_addr), .b_wdata (b_wdata), .b_we (b_we),
        .b_size (b_size), .b_sz_ex (b_sz_ex), .b_gnt (b_gnt), .b_done (b_done),
        .b_err (b_err), .b_rdata (b_rdata),
        .mem_address (mem_address), .mem_data_in (mem_data_in), .mem_wr_en (mem_wr_en),
        .mem_size (mem_size), .mem_sz_ex (mem_sz_ex), .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian memory: sized, extended combinational read; sized write on the edge.
    always_comb begin
        logic [7:0] i0, i1, i2, i3;
        i0 = mem_address[7:0];
        i1 = i0 + 8'd1;
        i2 = i0 + 8'd2;
        i3 = i0 + 8'd3;
        case (mem_size)
            2'b00:   mem_data_out = {{24{mem_sz_ex & mem[i0][7]}}, mem[i0]};
            2'b01:   mem_data_out = {{16{mem_sz_ex & mem[i1][7]}}, mem[i1], mem[i0]};
            default: mem_data_out = {mem[i3], mem[i2], mem[i1], mem[i0]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            wr_seen++;
            mem[mem_address[7:0]] <= mem_data_in[7:0];
            if (mem_size != 2'b00) mem[mem_address[7:0] + 8'd1] <= mem_data_in[15:8];
            if (mem_size == 2'b10) begin
                mem[mem_address[7:0] + 8'd2] <= mem_data_in[23:16];
                mem[mem_address[7:0] + 8'd3] <= mem_data_in[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on one port; returns rdata/err at done and the grant-to-done latency.
    task automatic xfer(input string tag, input logic port, input logic we,
                        input logic [31:0] addr, input logic [1:0] size, input logic sx,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        int n = 0;
        logic done_seen = 1'b0;
        @(negedge clk);
        if (port) begin
            b_req = 1; b_we = we; b_addr = addr; b_size = size; b_sz_ex = sx; b_wdata = wd;
        end else begin
            a_req = 1; a_we = we; a_addr = addr; a_size = size; a_sz_ex = sx; a_wdata = wd;
        end
        #1;
        while (!(port ? b_gnt : a_gnt) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_gnt"}, {31'd0, port ? b_gnt : a_gnt}, 32'd1);
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        lat = 0;
        while (!done_seen && lat < 6) begin
            @(negedge clk);
            lat++;
            done_seen = port ? b_done : a_done;
        end
        check({tag, "_other_done"}, {31'd0, port ? a_done : b_done}, 32'd0);
        rd = port ? b_rdata : a_rdata;
        er = port ? b_err : a_err;
        $display("xfer %s port=%0d we=%0d addr=0x%0h size=%0d rdata=0x%08h err=%0d lat=%0d",
                 tag, port, we, addr, size, rd, er, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          gcyc [3];
        logic        gwho [3];
        int          ng, cyc;

        rst = 0;
        a_req = 1; b_req = 0; a_we = 0; b_we = 0; a_sz_ex = 0; b_sz_ex = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0; a_size = 2'b10; b_size = 2'b10;
        #12;
        check("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        check("rst_done", {30'd0, a_done, b_done}, 32'd0);
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        check("rst_mem_size", {30'd0, mem_size}, 32'd2);
        a_req = 0;
        @(negedge clk); rst = 1;

        // Simultaneous requests held high: A, B, A with 3-cycle spacing.
        @(negedge clk);
        a_req = 1; b_req = 1;
        ng = 0; cyc = 0;
        while (ng < 3 && cyc < 20) begin
            #1;
            if (a_gnt || b_gnt) begin
                gcyc[ng] = cyc; gwho[ng] = b_gnt; ng++;
            end
            @(negedge clk); cyc++;
        end
        a_req = 0; b_req = 0;
        check("rr_grants", ng, 3);
        check("rr_first", {31'd0, gwho[0]}, 32'd0);
        check("rr_second", {31'd0, gwho[1]}, 32'd1);
        check("rr_third", {31'd0, gwho[2]}, 32'd0);
        check("rr_gap1", gcyc[1] - gcyc[0], 3);
        check("rr_gap2", gcyc[2] - gcyc[1], 3);
        $display("xfer rr grants=%0d order=%0d%0d%0d", ng, gwho[0], gwho[1], gwho[2]);
        repeat (3) @(negedge clk);

        // Word write then sign-extended byte read.
        xfer("a_wr0", 0, 1, 0, 2'b10, 0, 32'h000000FF, rd, er, lat);
        check("a_wr0_lat", lat, 2);
        check("a_wr0_err", {31'd0, er}, 32'd0);
        xfer("a_rd0", 0, 0, 0, 2'b00, 1, 0, rd, er, lat);
        check("a_rd0_lat", lat, 2);
        check("a_rd0_data", rd, 32'hFFFFFFFF);

        // Half word on port B with zero and sign extension.
        xfer("b_wr8", 1, 1, 8, 2'b01, 0, 32'h0000FFFF, rd, er, lat);
        xfer("b_rd8z", 1, 0, 8, 2'b01, 0, 0, rd, er, lat);
        check("b_rd8z_data", rd, 32'h0000FFFF);
        xfer("b_rd8s", 1, 0, 8, 2'b01, 1, 0, rd, er, lat);
        check("b_rd8s_data", rd, 32'hFFFFFFFF);

        // Baseline contents for the rejected accesses.
        xfer("a_wr4", 0, 1, 4, 2'b10, 0, 32'h11223344, rd, er, lat);
        xfer("a_wr254", 0, 1, 254, 2'b01, 0, 32'h00001234, rd, er, lat);
        xfer("a_wr12", 0, 1, 12, 2'b10, 0, 32'hA5A5A5A5, rd, er, lat);

        wr_seen = 0;
        xfer("e_w6", 1, 1, 6, 2'b10, 0, 32'hDEADBEEF, rd, er, lat);
        check("e_w6_lat", lat, 1);
        check("e_w6_err", {31'd0, er}, 32'd1);
        check("e_w6_rdata_kept", rd, 32'hFFFFFFFF);
        xfer("e_h3", 0, 1, 3, 2'b01, 0, 32'h0000BEEF, rd, er, lat);
        check("e_h3_lat", lat, 1);
        check("e_h3_err", {31'd0, er}, 32'd1);
        xfer("e_s11", 0, 1, 0, 2'b11, 0, 32'hCAFECAFE, rd, er, lat);
        check("e_s11_lat", lat, 1);
        check("e_s11_err", {31'd0, er}, 32'd1);
        xfer("e_w254", 1, 1, 254, 2'b10, 0, 32'hDEADBEEF, rd, er, lat);
        check("e_w254_lat", lat, 1);
        check("e_w254_err", {31'd0, er}, 32'd1);
        check("e_wr_en_seen", wr_seen, 0);

        xfer("r_w4", 0, 0, 4, 2'b10, 0, 0, rd, er, lat);
        check("r_w4_data", rd, 32'h11223344);
        check("r_w4_err", {31'd0, er}, 32'd0);
        xfer("r_w0", 0, 0, 0, 2'b10, 0, 0, rd, er, lat);
        check("r_w0_data", rd, 32'h000000FF);
        xfer("r_h254", 1, 0, 254, 2'b01, 0, 0, rd, er, lat);
        check("r_h254_data", rd, 32'h00001234);

        // Reset in the middle of ACCESS aborts the write.
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 12; a_size = 2'b10; a_wdata = 32'hFFFFFFFF;
        #1;
        check("abort_gnt", {31'd0, a_gnt}, 32'd1);
        @(posedge clk); #1;
        a_req = 0;
        check("abort_in_access", {31'd0, mem_wr_en}, 32'd1);
        #2 rst = 0;
        #1;
        check("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("abort_done", {31'd0, a_done}, 32'd0);
        @(negedge clk);
        check("abort_done_later", {30'd0, a_done, b_done}, 32'd0);
        check("abort_rdata_rst", a_rdata, 32'd0);
        rst = 1;
        xfer("r_w12", 0, 0, 12, 2'b10, 0, 0, rd, er, lat);
        check("r_w12_data", rd, 32'hA5A5A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
